// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback, owns the memory handshake,
// counts retired instructions and traps. Optional macro OVERFLOW_TRAP_EN enables signed-overflow traps.
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OPCode,
    input  logic [5:0]       funct,
    input  logic             zeroFlag,
    input  logic             overflow,
    input  logic             mem_ready,
    output logic             PCWE,
    output logic             IRWE,
    output logic             IorD,
    output logic             MemRE,
    output logic             MemWE,
    output logic             RegWE,
    output logic [1:0]       RegDst,
    output logic             memToReg,
    output logic             ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [2:0]       ALUcntrl,
    output logic [1:0]       PCsrc,
    output logic [3:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_WB_ALU   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       isR;
        logic       isLw;
        logic       isBne;
        logic       isJal;
        logic       isJr;
        logic       ovfChk;
        logic [2:0] alu;
    } class_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [7:0] W_LAST  = 8'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    class_t           r_class;
    logic [7:0]       r_waitCnt;
    logic [CNT_W-1:0] r_retired;
    logic             r_trap;
    logic [1:0]       r_trapCause;
    logic             r_iorD, r_memRE, r_memWE, r_regWE, r_memToReg, r_aluA, r_pcwe;
    logic [1:0]       r_regDst, r_aluB, r_pcSrc;
    logic [2:0]       r_aluCtl;

    state_t     w_decTarget, w_next;
    class_t     w_decClass, w_class;
    logic [1:0] w_cause;
    logic       w_retire, w_memState, w_timeout, w_waitInc, w_branchTaken, w_ovfTrap;
    logic       w_iorD, w_memRE, w_memWE, w_regWE, w_memToReg, w_aluA, w_pcwe;
    logic [1:0] w_regDst, w_aluB, w_pcSrc;
    logic [2:0] w_aluCtl;

    // Instruction classification, used in DECODE and latched for the later states.
    always_comb begin
        w_decClass  = '0;
        w_decTarget = S_TRAP;
        case (OPCode)
            6'h00: begin
                w_decClass.isR = 1'b1;
                case (funct)
                    6'h20: begin w_decClass.alu = ALU_ADD; w_decClass.ovfChk = 1'b1; w_decTarget = S_EXEC_R; end
                    6'h22: begin w_decClass.alu = ALU_SUB; w_decClass.ovfChk = 1'b1; w_decTarget = S_EXEC_R; end
                    6'h2a: begin w_decClass.alu = ALU_SLT; w_decTarget = S_EXEC_R; end
                    6'h08: begin w_decClass.isJr = 1'b1; w_decTarget = S_JUMP; end
                    default: w_decTarget = S_TRAP;
                endcase
            end
            6'h23: begin w_decClass.isLw = 1'b1; w_decTarget = S_MEM_ADDR; end
            6'h2b: w_decTarget = S_MEM_ADDR;
            6'h04: w_decTarget = S_BRANCH;
            6'h05: begin w_decClass.isBne = 1'b1; w_decTarget = S_BRANCH; end
            6'h02: w_decTarget = S_JUMP;
            6'h03: begin w_decClass.isJal = 1'b1; w_decTarget = S_JUMP; end
            6'h08: begin w_decClass.alu = ALU_ADD; w_decClass.ovfChk = 1'b1; w_decTarget = S_EXEC_I; end
            6'h0e: begin w_decClass.alu = ALU_XOR; w_decTarget = S_EXEC_I; end
            default: w_decTarget = S_TRAP;
        endcase
    end

    assign w_class       = (r_state == S_DECODE) ? w_decClass : r_class;
    assign w_memState    = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout     = w_memState && !mem_ready && (r_waitCnt == W_LAST);
    assign w_waitInc     = w_memState && !mem_ready && !w_timeout;
    assign w_branchTaken = (r_state == S_BRANCH) && (r_class.isBne ? !zeroFlag : zeroFlag);

`ifdef OVERFLOW_TRAP_EN
    assign w_ovfTrap = (r_state == S_WB_ALU) && r_class.ovfChk && overflow;
`else
    logic w_unusedOvf;
    assign w_unusedOvf = overflow & r_class.ovfChk;
    assign w_ovfTrap   = 1'b0;
`endif

    // Next-state, trap cause and retirement decisions.
    always_comb begin
        w_next   = r_state;
        w_cause  = r_trapCause;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b11; end
            end
            S_DECODE: begin
                w_next = w_decTarget;
                if (w_decTarget == S_TRAP) w_cause = 2'b01;
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_WB_ALU: begin
                if (w_ovfTrap) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end else begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_MEM_ADDR: w_next = r_class.isLw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b11; end
            end
            S_MEM_WB: begin w_next = S_FETCH; w_retire = 1'b1; end
            S_MEM_WR: begin
                if (mem_ready)      begin w_next = S_FETCH; w_retire = 1'b1; end
                else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b11; end
            end
            S_BRANCH, S_JUMP: begin w_next = S_FETCH; w_retire = 1'b1; end
            S_TRAP: w_next = S_TRAP;
            default: begin w_next = S_TRAP; w_cause = 2'b01; end
        endcase
    end

    // Moore decode of the state being entered, so the registered outputs line up with r_state.
    always_comb begin
        w_iorD     = 1'b0;
        w_memRE    = 1'b0;
        w_memWE    = 1'b0;
        w_regWE    = 1'b0;
        w_memToReg = 1'b0;
        w_aluA     = 1'b0;
        w_pcwe     = 1'b0;
        w_regDst   = 2'd0;
        w_aluB     = 2'd0;
        w_pcSrc    = 2'd0;
        w_aluCtl   = ALU_ADD;
        case (w_next)
            S_FETCH: begin w_memRE = 1'b1; w_aluB = 2'd1; end
            S_DECODE: w_aluB = 2'd2;
            S_EXEC_R: begin w_aluA = 1'b1; w_aluCtl = w_class.alu; end
            S_EXEC_I, S_MEM_ADDR: begin
                w_aluA   = 1'b1;
                w_aluB   = 2'd2;
                w_aluCtl = (w_next == S_EXEC_I) ? w_class.alu : ALU_ADD;
            end
            S_WB_ALU: begin
                w_regWE  = 1'b1;
                w_regDst = w_class.isR ? 2'd1 : 2'd0;
                w_aluA   = 1'b1;
                w_aluB   = w_class.isR ? 2'd0 : 2'd2;
                w_aluCtl = w_class.alu;
            end
            S_MEM_RD: begin w_memRE = 1'b1; w_iorD = 1'b1; end
            S_MEM_WB: begin w_regWE = 1'b1; w_memToReg = 1'b1; end
            S_MEM_WR: begin w_memWE = 1'b1; w_iorD = 1'b1; end
            S_BRANCH: begin w_aluA = 1'b1; w_aluCtl = ALU_SUB; w_pcSrc = 2'd1; end
            S_JUMP: begin
                w_pcwe  = 1'b1;
                w_pcSrc = w_class.isJr ? 2'd3 : 2'd2;
                if (w_class.isJal) begin
                    w_regWE  = 1'b1;
                    w_regDst = 2'd2;
                end
            end
            default: w_aluCtl = ALU_ADD;
        endcase
    end

    // Output flops reset to the FETCH decode; rst_n gating below forces everything to 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_class     <= '0;
            r_waitCnt   <= 8'd0;
            r_retired   <= '0;
            r_trap      <= 1'b0;
            r_trapCause <= 2'b00;
            r_iorD      <= 1'b0;
            r_memRE     <= 1'b1;
            r_memWE     <= 1'b0;
            r_regWE     <= 1'b0;
            r_memToReg  <= 1'b0;
            r_aluA      <= 1'b0;
            r_pcwe      <= 1'b0;
            r_regDst    <= 2'd0;
            r_aluB      <= 2'd1;
            r_pcSrc     <= 2'd0;
            r_aluCtl    <= ALU_ADD;
        end else begin
            r_state     <= w_next;
            if (r_state == S_DECODE) r_class <= w_decClass;
            r_waitCnt   <= w_waitInc ? r_waitCnt + 8'd1 : 8'd0;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
            r_trap      <= (w_next == S_TRAP);
            r_trapCause <= w_cause;
            r_iorD      <= w_iorD;
            r_memRE     <= w_memRE;
            r_memWE     <= w_memWE;
            r_regWE     <= w_regWE;
            r_memToReg  <= w_memToReg;
            r_aluA      <= w_aluA;
            r_pcwe      <= w_pcwe;
            r_regDst    <= w_regDst;
            r_aluB      <= w_aluB;
            r_pcSrc     <= w_pcSrc;
            r_aluCtl    <= w_aluCtl;
        end
    end

    assign PCWE       = rst_n & (((r_state == S_FETCH) & mem_ready) | r_pcwe | w_branchTaken);
    assign IRWE       = rst_n & (r_state == S_FETCH) & mem_ready;
    assign IorD       = rst_n & r_iorD;
    assign MemRE      = rst_n & r_memRE;
    assign MemWE      = rst_n & r_memWE;
    assign RegWE      = rst_n & r_regWE & !w_ovfTrap;
    assign RegDst     = {2{rst_n}} & r_regDst;
    assign memToReg   = rst_n & r_memToReg;
    assign ALUsrcA    = rst_n & r_aluA;
    assign ALUsrcB    = {2{rst_n}} & r_aluB;
    assign ALUcntrl   = {3{rst_n}} & r_aluCtl;
    assign PCsrc      = {2{rst_n}} & r_pcSrc;
    assign state      = r_state;
    assign trap       = r_trap;
    assign trap_cause = r_trapCause;
    assign retired    = r_retired;

endmodule
